scale_ratio_calc: RTL

- Computes the Q0.16 horizontal and vertical step ratios (x_radio, y_radio) consumed by the nearest-neighbour scaler from the programmed source and destination image sizes.
- Uses a single shared iterative restoring divider.
- Sits beside the scaler's write side on clk_in1 and recomputes automatically whenever any size input changes.
- New ratios are committed only during vertical blanking (per_img_vsync low), so a frame is never scaled with mixed ratios.

---
 rtl/scale_ratio_calc.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/scale_ratio_calc.sv
// Computes Q0.16 step ratios src/dst for the nearest-neighbour scaler with one shared restoring divider.
// Latency: 56 cycles from a size change seen in IDLE to new outputs (27 cycles per axis + commit), when vsync is low.
// Backpressure: results wait in S_COMMIT while per_img_vsync is high; size changes arriving while busy are picked up afterwards.
module scale_ratio_calc #(
  parameter int SIZE_W = 11,
  parameter int FRAC_W = 16
) (
  input  logic              clk_in1,
  input  logic              rst_n,
  input  logic [SIZE_W-1:0] src_img_width,
  input  logic [SIZE_W-1:0] src_img_height,
  input  logic [SIZE_W-1:0] dst_img_width,
  input  logic [SIZE_W-1:0] dst_img_height,
  input  logic              per_img_vsync,
  output logic [FRAC_W-1:0] x_radio,
  output logic [FRAC_W-1:0] y_radio,
  output logic              ratio_valid,
  output logic              busy,
  output logic              div_err
);

  // Dividend is {src, FRAC_W zeros}; one quotient bit is produced per cycle.
  localparam int DIV_W = SIZE_W + FRAC_W;
  localparam int IDX_W = $clog2(DIV_W);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(DIV_W - 1);
  localparam logic [FRAC_W-1:0] RATIO_SAT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_X,
    S_DIV_Y,
    S_COMMIT
  } state_t;

  state_t state_q;

  // Snapshot of the sizes the current/last computation was started from.
  logic [SIZE_W-1:0] snap_src_w;
  logic [SIZE_W-1:0] snap_src_h;
  logic [SIZE_W-1:0] snap_dst_w;
  logic [SIZE_W-1:0] snap_dst_h;
  logic              snap_vld;

  // Shared divider datapath.
  logic [DIV_W-1:0]  dvd_q;
  logic [SIZE_W-1:0] dvs_q;
  logic [SIZE_W:0]   rem_q;
  logic [DIV_W-1:0]  quo_q;
  logic [IDX_W-1:0]  idx_q;

  logic [SIZE_W:0]   rem_shift;
  logic [SIZE_W:0]   rem_next;
  logic [DIV_W-1:0]  quo_next;

  // Per-axis results held until the commit window opens.
  logic [FRAC_W-1:0] x_res_q;
  logic [FRAC_W-1:0] y_res_q;
  logic              err_x_q;
  logic              err_y_q;

  logic              size_change;
  logic              trigger;
  logic              last_bit;

  // Zero divisor or an integer part in the quotient both clamp to the largest ratio.
  function automatic logic [FRAC_W-1:0] axis_result(
    input logic [SIZE_W-1:0] dvs,
    input logic [DIV_W-1:0]  quo
  );
    if (dvs == '0 || quo[DIV_W-1:FRAC_W] != '0) begin
      return RATIO_SAT;
    end
    return quo[FRAC_W-1:0];
  endfunction

  // Detect a new request: nothing latched yet, or any size differs from the snapshot.
  always_comb begin
    size_change = (src_img_width  != snap_src_w) ||
                  (src_img_height != snap_src_h) ||
                  (dst_img_width  != snap_dst_w) ||
                  (dst_img_height != snap_dst_h);
    trigger     = !snap_vld || size_change;
    last_bit    = (idx_q == '0);
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q[SIZE_W-1:0], dvd_q[idx_q]};
    rem_next  = rem_shift;
    quo_next  = quo_q;
    if (rem_shift >= {1'b0, dvs_q}) begin
      rem_next        = rem_shift - {1'b0, dvs_q};
      quo_next[idx_q] = 1'b1;
    end else begin
      quo_next[idx_q] = 1'b0;
    end
  end

  // Control FSM with divider registers and registered outputs.
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      snap_src_w  <= '0;
      snap_src_h  <= '0;
      snap_dst_w  <= '0;
      snap_dst_h  <= '0;
      snap_vld    <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      idx_q       <= '0;
      x_res_q     <= '0;
      y_res_q     <= '0;
      err_x_q     <= 1'b0;
      err_y_q     <= 1'b0;
      x_radio     <= '0;
      y_radio     <= '0;
      ratio_valid <= 1'b0;
      busy        <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            snap_src_w <= src_img_width;
            snap_src_h <= src_img_height;
            snap_dst_w <= dst_img_width;
            snap_dst_h <= dst_img_height;
            snap_vld   <= 1'b1;
            dvd_q      <= {src_img_width, {FRAC_W{1'b0}}};
            dvs_q      <= dst_img_width;
            rem_q      <= '0;
            quo_q      <= '0;
            idx_q      <= IDX_TOP;
            busy       <= 1'b1;
            state_q    <= S_DIV_X;
          end
        end

        S_DIV_X: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          idx_q <= idx_q - IDX_W'(1);
          if (last_bit) begin
            x_res_q <= axis_result(dvs_q, quo_next);
            err_x_q <= (dvs_q == '0);
            // Vertical axis comes from the snapshot so late input changes cannot mix in.
            dvd_q   <= {snap_src_h, {FRAC_W{1'b0}}};
            dvs_q   <= snap_dst_h;
            rem_q   <= '0;
            quo_q   <= '0;
            idx_q   <= IDX_TOP;
            state_q <= S_DIV_Y;
          end
        end

        S_DIV_Y: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          idx_q <= idx_q - IDX_W'(1);
          if (last_bit) begin
            y_res_q <= axis_result(dvs_q, quo_next);
            err_y_q <= (dvs_q == '0);
            state_q <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          // Hold the pair until vertical blanking so a frame never sees mixed ratios.
          if (!per_img_vsync) begin
            x_radio     <= x_res_q;
            y_radio     <= y_res_q;
            div_err     <= err_x_q | err_y_q;
            ratio_valid <= 1'b1;
            busy        <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
